sap1_controller_sequencer: RTL and testbench

//  Control sequencer for the SAP-1 datapath. Steps a six-state ring (T1..T6)
//  per instruction: fetch in T1-T3, execute in T4-T6 decoded from the IR opcode.

---
 rtl/sap1_ctrl_if.sv | 41 ++++
 rtl/sap1_controller_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_ctrl_if.sv
// Control-sequencer bundle: mode inputs, opcode and the SAP-1 control word.
interface sap1_ctrl_if #(
   parameter int unsigned OPW = 4
);
   logic           run;
   logic           step;
   logic           soft_clear;
   logic [OPW-1:0] opcode;
   logic           pc_clear;
   logic           pc_inc;
   logic           pc_out;
   logic           mar_load;
   logic           ram_out;
   logic           ir_load;
   logic           ir_out;
   logic           a_load;
   logic           a_out;
   logic           b_load;
   logic           alu_sub;
   logic           alu_out;
   logic           out_load;
   logic [5:0]     t_state;
   logic           instr_done;
   logic           halted;

   // Sequencer side: consumes mode/opcode, drives the control word.
   modport master (
      input  run, step, soft_clear, opcode,
      output pc_clear, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
             a_load, a_out, b_load, alu_sub, alu_out, out_load,
             t_state, instr_done, halted
   );

   // Datapath/front-panel side.
   modport slave (
      output run, step, soft_clear, opcode,
      input  pc_clear, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
             a_load, a_out, b_load, alu_sub, alu_out, out_load,
             t_state, instr_done, halted
   );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: T1..T6 ring with fetch in T1-T3 and
// opcode-decoded execute in T4-T6; free-run, step, soft clear and HLT.
module sap1_controller_sequencer #(
   parameter int unsigned    OPW    = 4,
   parameter logic [OPW-1:0] OP_LDA = OPW'(4'h0),
   parameter logic [OPW-1:0] OP_ADD = OPW'(4'h1),
   parameter logic [OPW-1:0] OP_SUB = OPW'(4'h2),
   parameter logic [OPW-1:0] OP_OUT = OPW'(4'hE),
   parameter logic [OPW-1:0] OP_HLT = OPW'(4'hF)
) (
   input  logic        clock,
   input  logic        reset_n,
   sap1_ctrl_if.master bus
);

   localparam int unsigned TW = 6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } state_e;

   state_e state_q;
   state_e state_d;

   logic          is_lda;
   logic          is_alu;
   logic          is_sub;
   logic          is_out;
   logic          is_hlt;

   logic          pc_clear_c;
   logic          pc_inc_c;
   logic          pc_out_c;
   logic          mar_load_c;
   logic          ram_out_c;
   logic          ir_load_c;
   logic          ir_out_c;
   logic          a_load_c;
   logic          a_out_c;
   logic          b_load_c;
   logic          alu_sub_c;
   logic          alu_out_c;
   logic          out_load_c;
   logic [TW-1:0] t_state_c;
   logic          instr_done_c;
   logic          halted_c;

   // Opcode class decode shared by next-state and output logic.
   always_comb begin
      is_lda = (bus.opcode == OP_LDA);
      is_sub = (bus.opcode == OP_SUB);
      is_alu = (bus.opcode == OP_ADD) || is_sub;
      is_out = (bus.opcode == OP_OUT);
      is_hlt = (bus.opcode == OP_HLT);
   end

   // State register; reset aborts any instruction immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: soft_clear wins, otherwise step the T-ring.
   always_comb begin
      state_d = state_q;
      if (bus.soft_clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.run || bus.step) state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = is_hlt ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = bus.run ? S_T1 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control word decode from state and opcode.
   always_comb begin
      pc_clear_c   = 1'b0;
      pc_inc_c     = 1'b0;
      pc_out_c     = 1'b0;
      mar_load_c   = 1'b0;
      ram_out_c    = 1'b0;
      ir_load_c    = 1'b0;
      ir_out_c     = 1'b0;
      a_load_c     = 1'b0;
      a_out_c      = 1'b0;
      b_load_c     = 1'b0;
      alu_sub_c    = 1'b0;
      alu_out_c    = 1'b0;
      out_load_c   = 1'b0;
      t_state_c    = '0;
      instr_done_c = 1'b0;
      halted_c     = 1'b0;
      case (state_q)
         S_T1: begin
            t_state_c  = TW'(6'b000001);
            pc_out_c   = 1'b1;
            mar_load_c = 1'b1;
         end
         S_T2: begin
            t_state_c = TW'(6'b000010);
            pc_inc_c  = 1'b1;
         end
         S_T3: begin
            t_state_c = TW'(6'b000100);
            ram_out_c = 1'b1;
            ir_load_c = 1'b1;
         end
         S_T4: begin
            t_state_c = TW'(6'b001000);
            if (is_lda || is_alu) begin
               ir_out_c   = 1'b1;
               mar_load_c = 1'b1;
            end else if (is_out) begin
               a_out_c    = 1'b1;
               out_load_c = 1'b1;
            end
         end
         S_T5: begin
            t_state_c = TW'(6'b010000);
            if (is_lda) begin
               ram_out_c = 1'b1;
               a_load_c  = 1'b1;
            end else if (is_alu) begin
               ram_out_c = 1'b1;
               b_load_c  = 1'b1;
            end
         end
         S_T6: begin
            t_state_c    = TW'(6'b100000);
            instr_done_c = 1'b1;
            if (is_alu) begin
               alu_out_c = 1'b1;
               a_load_c  = 1'b1;
               alu_sub_c = is_sub;
            end
         end
         S_HALT:  halted_c = 1'b1;
         default: ;
      endcase
      // Soft clear suppresses the whole control word except the PC clear.
      if (bus.soft_clear) begin
         pc_clear_c   = reset_n;
         pc_inc_c     = 1'b0;
         pc_out_c     = 1'b0;
         mar_load_c   = 1'b0;
         ram_out_c    = 1'b0;
         ir_load_c    = 1'b0;
         ir_out_c     = 1'b0;
         a_load_c     = 1'b0;
         a_out_c      = 1'b0;
         b_load_c     = 1'b0;
         alu_sub_c    = 1'b0;
         alu_out_c    = 1'b0;
         out_load_c   = 1'b0;
         instr_done_c = 1'b0;
      end
   end

   assign bus.pc_clear   = pc_clear_c;
   assign bus.pc_inc     = pc_inc_c;
   assign bus.pc_out     = pc_out_c;
   assign bus.mar_load   = mar_load_c;
   assign bus.ram_out    = ram_out_c;
   assign bus.ir_load    = ir_load_c;
   assign bus.ir_out     = ir_out_c;
   assign bus.a_load     = a_load_c;
   assign bus.a_out      = a_out_c;
   assign bus.b_load     = b_load_c;
   assign bus.alu_sub    = alu_sub_c;
   assign bus.alu_out    = alu_out_c;
   assign bus.out_load   = out_load_c;
   assign bus.t_state    = t_state_c;
   assign bus.instr_done = instr_done_c;
   assign bus.halted     = halted_c;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Scoreboard bench: the driver pushes the expected control word per cycle,
// the monitor pops and compares it against the DUT half a cycle later.
module tb_sap1_controller_sequencer;

   logic clock;
   logic reset_n;

   sap1_ctrl_if #(.OPW(4)) bus ();

   sap1_controller_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [12:0] C_PC_CLEAR = 13'h1000;
   localparam logic [12:0] C_PC_INC   = 13'h0800;
   localparam logic [12:0] C_PC_OUT   = 13'h0400;
   localparam logic [12:0] C_MAR_LOAD = 13'h0200;
   localparam logic [12:0] C_RAM_OUT  = 13'h0100;
   localparam logic [12:0] C_IR_LOAD  = 13'h0080;
   localparam logic [12:0] C_IR_OUT   = 13'h0040;
   localparam logic [12:0] C_A_LOAD   = 13'h0020;
   localparam logic [12:0] C_A_OUT    = 13'h0010;
   localparam logic [12:0] C_B_LOAD   = 13'h0008;
   localparam logic [12:0] C_ALU_SUB  = 13'h0004;
   localparam logic [12:0] C_ALU_OUT  = 13'h0002;
   localparam logic [12:0] C_OUT_LOAD = 13'h0001;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef struct {
      logic [20:0] vec;
      logic [20:0] mask;
      string       tag;
   } exp_t;

   exp_t        q[$];
   logic [12:0] tbl [0:5][1:6];
   int          m_t;      // 0 idle, 1..6 = T-step of current instruction, 7 halted
   string       phase;
   int          checks;
   int          errors;

   function automatic int op_class(input logic [3:0] op);
      case (op)
         OP_LDA:  return 0;
         OP_ADD:  return 1;
         OP_SUB:  return 2;
         OP_OUT:  return 3;
         OP_HLT:  return 4;
         default: return 5;
      endcase
   endfunction

   task automatic build_table();
      for (int c = 0; c < 6; c++) begin
         tbl[c][1] = C_PC_OUT | C_MAR_LOAD;
         tbl[c][2] = C_PC_INC;
         tbl[c][3] = C_RAM_OUT | C_IR_LOAD;
         for (int t = 4; t <= 6; t++) tbl[c][t] = '0;
      end
      tbl[0][4] = C_IR_OUT | C_MAR_LOAD;
      tbl[0][5] = C_RAM_OUT | C_A_LOAD;
      for (int c = 1; c <= 2; c++) begin
         tbl[c][4] = C_IR_OUT | C_MAR_LOAD;
         tbl[c][5] = C_RAM_OUT | C_B_LOAD;
         tbl[c][6] = C_ALU_OUT | C_A_LOAD;
      end
      tbl[2][6] = tbl[2][6] | C_ALU_SUB;
      tbl[3][4] = C_A_OUT | C_OUT_LOAD;
   endtask

   // One clock cycle of stimulus plus its predicted response.
   task automatic do_cycle(input bit r, input bit s, input bit sc, input bit rn,
                           input logic [3:0] op);
      exp_t        e;
      logic [12:0] ctl;
      logic [5:0]  ts;
      @(posedge clock);
      #1;
      reset_n        = rn;
      bus.run        = r;
      bus.step       = s;
      bus.soft_clear = sc;
      bus.opcode     = (m_t >= 4 && m_t <= 6) ? op : 4'($urandom);
      e.tag  = phase;
      e.mask = '1;
      if (!rn) begin
         e.vec = '0;
         m_t   = 0;
      end else if (sc) begin
         e.vec  = {C_PC_CLEAR, 8'h00};
         e.mask = {13'h1FFF, 6'h00, 1'b1, 1'b0};
         m_t    = 0;
      end else begin
         ctl = '0;
         ts  = '0;
         if (m_t >= 1 && m_t <= 6) begin
            ctl = tbl[op_class(bus.opcode)][m_t];
            ts  = 6'(1 << (m_t - 1));
         end
         e.vec = {ctl, ts, 1'(m_t == 6), 1'(m_t == 7)};
         if (m_t == 0)                          m_t = (r || s) ? 1 : 0;
         else if (m_t == 4 && bus.opcode == OP_HLT) m_t = 7;
         else if (m_t == 6)                     m_t = r ? 1 : 0;
         else if (m_t != 7)                     m_t = m_t + 1;
      end
      q.push_back(e);
   endtask

   // Monitor: compare every presented cycle against the scoreboard.
   initial begin
      exp_t        e;
      logic [20:0] act;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.pc_clear, bus.pc_inc, bus.pc_out, bus.mar_load, bus.ram_out,
                   bus.ir_load, bus.ir_out, bus.a_load, bus.a_out, bus.b_load,
                   bus.alu_sub, bus.alu_out, bus.out_load, bus.t_state,
                   bus.instr_done, bus.halted};
            checks++;
            if ((act & e.mask) !== (e.vec & e.mask)) begin
               errors++;
               $display("FAIL %s t=%0t got=%06h exp=%06h mask=%06h",
                        e.tag, $time, act, e.vec, e.mask);
            end
            checks++;
            if ($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out}) > 1) begin
               errors++;
               $display("FAIL one_driver t=%0t got=%0d drivers exp<=1", $time,
                        $countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out}));
            end
         end
      end
   end

   initial begin
      logic [3:0] ops [4];
      logic [3:0] rop;
      bit         rn;
      bit         sc;
      checks = 0;
      errors = 0;
      m_t    = 0;
      reset_n        = 1'b0;
      bus.run        = 1'b0;
      bus.step       = 1'b0;
      bus.soft_clear = 1'b0;
      bus.opcode     = '0;
      build_table();
      ops[0] = OP_LDA; ops[1] = OP_ADD; ops[2] = OP_SUB; ops[3] = OP_OUT;

      phase = "reset";
      repeat (2) do_cycle(0, 0, 0, 0, 4'h0);

      phase = "free_run";
      do_cycle(1, 0, 0, 1, 4'h0);
      for (int i = 0; i < 4; i++) repeat (6) do_cycle(1, 0, 0, 1, ops[i]);

      phase = "reset_mid_t5";
      repeat (4) do_cycle(1, 0, 0, 1, OP_ADD);
      do_cycle(1, 0, 0, 0, OP_ADD);
      do_cycle(0, 0, 0, 0, OP_ADD);
      do_cycle(0, 0, 0, 1, OP_ADD);

      phase = "step";
      do_cycle(0, 1, 0, 1, OP_SUB);
      repeat (6) do_cycle(0, 1'($urandom), 0, 1, OP_SUB);
      repeat (4) do_cycle(0, 0, 0, 1, OP_SUB);

      phase = "halt";
      do_cycle(1, 0, 0, 1, OP_HLT);
      repeat (4) do_cycle(1, 0, 0, 1, OP_HLT);
      repeat (20) do_cycle(1, 1'($urandom), 0, 1, OP_HLT);

      phase = "soft_clear_halt";
      do_cycle(1, 0, 1, 1, OP_HLT);
      do_cycle(0, 0, 0, 1, OP_HLT);

      phase = "soft_clear_t3";
      do_cycle(1, 0, 0, 1, OP_LDA);
      repeat (2) do_cycle(1, 0, 0, 1, OP_LDA);
      do_cycle(1, 0, 1, 1, OP_LDA);
      do_cycle(0, 0, 0, 1, OP_LDA);

      phase = "nop";
      do_cycle(1, 0, 0, 1, 4'h7);
      repeat (12) do_cycle(1, 0, 0, 1, 4'h7);

      phase = "random";
      rop = OP_ADD;
      repeat (400) begin
         if (m_t == 1) rop = 4'($urandom);
         rn = ($urandom_range(0, 63) != 0);
         sc = ($urandom_range(0, 31) == 0);
         do_cycle(($urandom_range(0, 3) != 0), 1'($urandom), sc, rn, rop);
      end

      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
